// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Define IFETCH_PREFETCH_EN for a two-entry buffer with overlapped fetches.
package instr_fetch_pkg;
  localparam int INSTR_W = 16;
`ifdef IFETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Wishbone-classic instruction bus between the fetch stage and memory.
interface instr_fetch_if #(parameter int ADDR_W = 16);
  logic                                cyc_o;
  logic                                stb_o;
  logic [ADDR_W-1:0]                   adr_o;
  logic [instr_fetch_pkg::INSTR_W-1:0] dat_i;
  logic                                ack_i;

  modport master (output cyc_o, stb_o, adr_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, adr_o, output dat_i, ack_i);
endinterface

// File: rtl/instr_fetch_buf.sv
// One- or two-entry instruction/PC FIFO; entry 0 is the head register seen by
// the control unit. Flush only clears the count so instr holds its last value.
module ifetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic               valid_o,
  output logic [1:0]         count_o
);
  logic [1:0][INSTR_W-1:0] instr_q, instr_d;
  logic [1:0][ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]              cnt_q, cnt_d, wr_idx;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wr_idx  = cnt_q - {1'b0, pop_i};
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_i && cnt_q == 2'd2) begin
        instr_d[0] = instr_q[1];
        pc_d[0]    = pc_q[1];
      end
      if (push_i) begin
        if (wr_idx == 2'd0) begin
          instr_d[0] = push_instr_i;
          pc_d[0]    = push_pc_i;
        end else if (DEPTH > 1) begin
          instr_d[1] = push_instr_i;
          pc_d[1]    = push_pc_i;
        end
      end
      cnt_d = wr_idx + {1'b0, push_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= 2'd0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_instr_o = instr_q[0];
  assign head_pc_o    = pc_q[0];
  assign valid_o      = cnt_q != 2'd0;
  assign count_o      = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, Wishbone fetch FSM and instruction buffer.
// Buffer depth follows IFETCH_PREFETCH_EN (see instr_fetch_pkg).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      bus,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, adr_q, adr_d;
  logic              push, pop;
  logic [1:0]        cnt, occ_keep, occ_fill;
  logic              free_keep, free_fill;

  // A head popped this cycle frees its slot for the fetch decision.
  assign pop       = instr_valid & instr_ready & ~redirect;
  assign occ_keep  = cnt - {1'b0, pop};
  assign occ_fill  = occ_keep + 2'd1;
  assign free_keep = occ_keep < 2'(BUF_DEPTH);
  assign free_fill = occ_fill < 2'(BUF_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    adr_d   = adr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d    = redirect_addr;
          adr_d   = redirect_addr;
          state_d = FETCH;
        end else if (free_keep) begin
          adr_d   = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_addr;
          // An open bus cycle must still be acked before the new address goes out.
          if (bus.ack_i) adr_d = redirect_addr;
          else           state_d = DRAIN;
        end else if (bus.ack_i) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
          if (free_fill) adr_d = pc_q + ADDR_W'(1);
          else           state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d = redirect_addr;
          if (bus.ack_i) begin
            adr_d   = redirect_addr;
            state_d = FETCH;
          end
        end else if (bus.ack_i) begin
          adr_d   = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      adr_q   <= adr_d;
    end
  end

  assign bus.stb_o = state_q != IDLE;
  assign bus.cyc_o = bus.stb_o;
  assign bus.adr_o = adr_q;

  ifetch_buf #(.ADDR_W(ADDR_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .pop_i        (pop),
    .push_instr_i (bus.dat_i),
    .push_pc_i    (adr_q),
    .head_instr_o (instr),
    .head_pc_o    (instr_pc),
    .valid_o      (instr_valid),
    .count_o      (cnt)
  );
endmodule
